// File: rtl/aes_inv_key_expander.sv
// ---------------------------------------------------------------------------
// aes_inv_key_expander
//
// Purpose:
//   Inverse AES-128 key schedule. Loads the round-10 key and walks the
//   schedule backwards, presenting round keys 10, 9, ... 0 one per accepted
//   handshake. Only the current round key is stored. Each backwards step
//   is one combinational stage with four forward S-box lookups.
//
// Ports:
//   clk        in   1    rising-edge clock
//   rst_n      in   1    asynchronous active-low reset
//   start      in   1    load last_key and begin; sampled in IDLE or DONE only
//   last_key   in   128  round-10 key {w0,w1,w2,w3}; bit 127 is the MSB of w0
//   out_ready  in   1    consumer accepts round_key this cycle
//   out_valid  out  1    round_key / round_idx valid
//   round_key  out  128  current round key {w0,w1,w2,w3}; bit 127 = MSB of w0
//   round_idx  out  4    round number of round_key, 10 down to 0
//   busy       out  1    high while the schedule is running
//   done       out  1    one-cycle pulse after round 0 is accepted
//
// Handshake: a key is transferred on every rising edge where
//   out_valid && out_ready. While out_valid is high and out_ready is low,
//   round_key and round_idx hold their values. out_valid never drops
//   without a transfer, except on reset.
//
// Configuration macro:
//   AES_INVKEY_ZEROIZE_EN  when defined, the key register (and therefore
//                          round_key) is cleared on the edge that enters
//                          DONE. When undefined, the round-0 (cipher) key
//                          stays visible until the next start or reset.
//
// Debug: the FSM state is held in state_q (type state_t) for checkers.
// ---------------------------------------------------------------------------
module aes_inv_key_expander (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] last_key,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Forward AES S-box, entry x at bits [x*8 +: 8] counting from the MSB end.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [10:0] base;
    // Entry 0 sits at the top of the packed constant.
    base = 11'd2040 - {x, 3'b000};
    sbox = SBOX_TABLE[base +: 8];
  endfunction

  state_t       state_q, state_d;
  logic [127:0] key_q,   key_d;
  logic [3:0]   idx_q,   idx_d;
  logic         valid_q, valid_d;
  logic         busy_q,  busy_d;
  logic         done_q,  done_d;

  // ---------------------------------------------------------------------------
  // One backwards step of the key schedule, from key_q (round idx_q) to the
  // key of round idx_q-1.
  // ---------------------------------------------------------------------------
  logic [31:0] w0, w1, w2, w3;
  logic [31:0] p0, p1, p2, p3;
  logic [31:0] rot_p3, sub_p3;
  logic [7:0]  rcon;
  logic [127:0] prev_key;

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  assign p3 = w3 ^ w2;
  assign p2 = w2 ^ w1;
  assign p1 = w1 ^ w0;

  // p3 is the recovered previous w3, which is what the forward schedule fed
  // through RotWord/SubWord to build the current w0.
  assign rot_p3 = {p3[23:0], p3[31:24]};
  assign sub_p3 = {sbox(rot_p3[31:24]), sbox(rot_p3[23:16]),
                   sbox(rot_p3[15:8]),  sbox(rot_p3[7:0])};

  // Rcon belongs to the round being undone, i.e. the current index.
  always_comb begin
    rcon = 8'h00;
    case (idx_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign p0       = w0 ^ sub_p3 ^ {rcon, 24'h000000};
  assign prev_key = {p0, p1, p2, p3};

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;

    case (state_q)
      // DONE accepts start exactly like IDLE so jobs can run back to back.
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          key_d   = last_key;
          idx_d   = 4'd10;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        // start is deliberately not looked at here.
        if (valid_q && out_ready) begin
          if (idx_q != 4'd0) begin
            key_d = prev_key;
            idx_d = idx_q - 4'd1;
          end else begin
            state_d = ST_DONE;
`ifdef AES_INVKEY_ZEROIZE_EN
            key_d   = '0;
`endif
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered copies of the next state's decode.
    valid_d = (state_d == ST_RUN);
    busy_d  = (state_d == ST_RUN);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      idx_q   <= 4'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign out_valid = valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign round_key = key_q;
  assign round_idx = idx_q;

endmodule

// File: tb/tb_aes_inv_key_expander.sv
// ---------------------------------------------------------------------------
// tb_aes_inv_key_expander
//
// Directed bench for the inverse AES-128 key schedule. The reference model
// derives the S-box from GF(2^8) inversion plus the affine map, walks the
// schedule backwards word by word, and cross-checks itself with a forward
// FIPS-197 expansion. A queue of {idx,key} entries holds what the DUT must
// present; one negedge process compares every cycle.
// ---------------------------------------------------------------------------
module tb_aes_inv_key_expander;

  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FIPS_K9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] FIPS_K0  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] ZERO_K10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

`ifdef AES_INVKEY_ZEROIZE_EN
  localparam bit ZEROIZE = 1'b1;
`else
  localparam bit ZEROIZE = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0;
  logic [127:0] last_key = '0;
  logic         out_ready = 1'b0;
  logic         out_valid;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         busy;
  logic         done;

  always #5 clk = ~clk;

  aes_inv_key_expander dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .last_key  (last_key),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .round_key (round_key),
    .round_idx (round_idx),
    .busy      (busy),
    .done      (done)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] sbox_t [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x, y, p;
    x = a; y = b; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x};
    return d[15-n -: 8];
  endfunction

  function automatic logic [7:0] rcon_of(input int r);
    logic [7:0] v;
    v = 8'h01;
    for (int i = 1; i < r; i++) v = gmul(v, 8'h02);
    return v;
  endfunction

  function automatic logic [31:0] sub_rot(input logic [31:0] t);
    logic [31:0] r;
    r = {t[23:0], t[31:24]};
    return {sbox_t[r[31:24]], sbox_t[r[23:16]], sbox_t[r[15:8]], sbox_t[r[7:0]]};
  endfunction

  // Undo the forward recurrence one round at a time, from round 10 to r.
  function automatic logic [127:0] model_key(input logic [127:0] k10, input int r);
    logic [31:0] w [4];
    logic [31:0] p [4];
    for (int i = 0; i < 4; i++) w[i] = k10[127-32*i -: 32];
    for (int rr = 10; rr > r; rr--) begin
      p[3] = w[3] ^ w[2];
      p[2] = w[2] ^ w[1];
      p[1] = w[1] ^ w[0];
      p[0] = w[0] ^ sub_rot(p[3]) ^ {rcon_of(rr), 24'h0};
      for (int i = 0; i < 4; i++) w[i] = p[i];
    end
    return {w[0], w[1], w[2], w[3]};
  endfunction

  // Plain forward FIPS-197 expansion; returns round-10 key.
  function automatic logic [127:0] fwd_expand(input logic [127:0] k0);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k0[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) t = sub_rot(t) ^ {rcon_of(i/4), 24'h0};
      w[i] = w[i-4] ^ t;
    end
    return {w[40], w[41], w[42], w[43]};
  endfunction

  // ---------------- scoreboard state ----------------
  logic [131:0] exp_q [$];          // {idx[3:0], key[127:0]}
  bit           exp_done = 1'b0;
  logic [127:0] exp_idle_key = '0;
  logic [127:0] obs_key [11];

  // Model update: follows the bench-driven inputs at each edge.
  initial begin : model_proc
    logic [7:0]   inv, s;
    logic [131:0] e;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox_t[x] = s;
    end
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_q.delete();
        exp_done = 1'b0;
        exp_idle_key = '0;
      end else begin
        exp_done = 1'b0;
        if (exp_q.size() > 0) begin
          if (out_ready) begin
            e = exp_q.pop_front();
            if (e[131:128] == 4'd0) begin
              exp_done = 1'b1;
              exp_idle_key = ZEROIZE ? 128'h0 : e[127:0];
            end
          end
        end else if (start) begin
          for (int r = 10; r >= 0; r--)
            exp_q.push_back({4'(r), model_key(last_key, r)});
        end
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial begin : compare_proc
    logic ev;
    forever begin
      @(negedge clk);
      ev = (exp_q.size() > 0);
      check("out_valid", {127'h0, out_valid}, {127'h0, ev});
      check("busy", {127'h0, busy}, {127'h0, ev});
      check("done", {127'h0, done}, {127'h0, exp_done});
      if (ev) begin
        check("round_idx", {124'h0, round_idx}, {124'h0, exp_q[0][131:128]});
        check("round_key", round_key, exp_q[0][127:0]);
        if (out_valid && out_ready && round_idx <= 4'd10)
          obs_key[round_idx] = round_key;
      end else begin
        check("idle_round_idx", {124'h0, round_idx}, 128'h0);
        check("idle_round_key", round_key, exp_idle_key);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_obs();
    for (int i = 0; i < 11; i++) obs_key[i] = 'x;
  endtask

  task automatic start_job(input logic [127:0] k);
    @(posedge clk); #1;
    last_key = k;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  // Start from inside the DONE cycle.
  task automatic start_now(input logic [127:0] k);
    last_key = k;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  // ready_mode 0: always ready; 1: random. poke5 reasserts start with junk at idx 5.
  task automatic drain(input int ready_mode, input bit poke5, output int cyc);
    bit poked;
    poked = 1'b0;
    cyc = 1;
    forever begin
      out_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      start = 1'b0;
      if (poke5 && !poked && out_valid && round_idx == 4'd5) begin
        start    = 1'b1;
        last_key = {$urandom, $urandom, $urandom, $urandom};
        poked    = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
      if (done) break;
      if (cyc > 300) begin
        check("drain_timeout", 128'(cyc), 128'd0);
        break;
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin : main_proc
    int cyc;
    logic [127:0] rk;

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    // Pin the model against published values and forward expansion.
    check("model_idx9", model_key(FIPS_K10, 9), FIPS_K9);
    check("model_idx0", model_key(FIPS_K10, 0), FIPS_K0);
    check("model_zero_idx0", model_key(ZERO_K10, 0), 128'h0);
    check("model_fwd_fips", fwd_expand(FIPS_K0), FIPS_K10);
    check("model_fwd_zero", fwd_expand(128'h0), ZERO_K10);

    // FIPS vector, always ready.
    out_ready = 1'b1;
    clear_obs();
    start_job(FIPS_K10);
    drain(0, 1'b0, cyc);
    check("fips_done_cycle", 128'(cyc), 128'd12);
    check("fips_idx10", obs_key[10], FIPS_K10);
    check("fips_idx9", obs_key[9], FIPS_K9);
    check("fips_idx0", obs_key[0], FIPS_K0);
    @(posedge clk); #1;
    check("idle_key_after_fips", round_key, ZEROIZE ? 128'h0 : FIPS_K0);

    // Random backpressure.
    clear_obs();
    start_job(FIPS_K10);
    drain(1, 1'b0, cyc);
    check("bp_idx9", obs_key[9], FIPS_K9);
    check("bp_idx0", obs_key[0], FIPS_K0);

    // start reasserted mid-run with a junk key must be ignored.
    rk = {$urandom, $urandom, $urandom, $urandom};
    clear_obs();
    start_job(rk);
    drain(1, 1'b1, cyc);
    check("poke_idx10", obs_key[10], rk);
    check("poke_idx0", obs_key[0], model_key(rk, 0));

    // Back-to-back: second start issued in the DONE cycle.
    start_job(FIPS_K10);
    drain(0, 1'b0, cyc);
    check("b2b_in_done", {127'h0, done}, 128'h1);
    clear_obs();
    start_now(ZERO_K10);
    check("b2b_valid", {127'h0, out_valid}, 128'h1);
    check("b2b_idx10", {124'h0, round_idx}, 128'd10);
    check("b2b_key10", round_key, ZERO_K10);
    drain(0, 1'b0, cyc);
    check("b2b_zero_idx0", obs_key[0], 128'h0);

    // Reset at idx 3 aborts immediately.
    start_job(FIPS_K10);
    cyc = 0;
    while (round_idx != 4'd3 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("rst_reached_idx3", {124'h0, round_idx}, 128'd3);
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", {127'h0, out_valid}, 128'h0);
    check("rst_busy", {127'h0, busy}, 128'h0);
    check("rst_round_key", round_key, 128'h0);
    check("rst_done", {127'h0, done}, 128'h0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // Fresh job after reset, ending with the FIPS round-0 key.
    clear_obs();
    start_job(FIPS_K10);
    drain(0, 1'b0, cyc);
    check("post_rst_done_cycle", 128'(cyc), 128'd12);
    check("post_rst_idx10", obs_key[10], FIPS_K10);
    check("post_rst_idx0", obs_key[0], FIPS_K0);
    repeat (2) @(posedge clk); #1;
    check("final_idle_key", round_key, ZEROIZE ? 128'h0 : FIPS_K0);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
